// File: rtl/instr_encoder_if.sv
// Request/response bundle between an instruction producer and instr_encoder.
// The slave modport is the encoder side; master is the producer/consumer side.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        err;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, err
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
        output in_ready, out_valid, out_instr, err
    );
endinterface

// File: rtl/instr_encoder.sv
// MIPS instruction encoder feeding a DEPTH-entry output FIFO.
// Macro INSTR_ENCODER_LI_EN enables the two-word LI pseudo-op (LUI + ORI).
//
// state   | meaning
// S_IDLE  | accepting requests whenever the FIFO has room
// S_LI_LO | LUI queued; waiting for FIFO room to queue the ORI low half
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [3:0] OP_ADDU  = 4'd0;
    localparam logic [3:0] OP_SUBU  = 4'd1;
    localparam logic [3:0] OP_SLT   = 4'd2;
    localparam logic [3:0] OP_JR    = 4'd3;
    localparam logic [3:0] OP_ORI   = 4'd4;
    localparam logic [3:0] OP_LW    = 4'd5;
    localparam logic [3:0] OP_SW    = 4'd6;
    localparam logic [3:0] OP_BEQ   = 4'd7;
    localparam logic [3:0] OP_LUI   = 4'd8;
    localparam logic [3:0] OP_J     = 4'd9;
    localparam logic [3:0] OP_ADDI  = 4'd10;
    localparam logic [3:0] OP_ADDIU = 4'd11;
    localparam logic [3:0] OP_JAL   = 4'd12;
    localparam logic [3:0] OP_LI    = 4'd13;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_err;

    logic          w_full;
    logic          w_out_valid;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_pop;
    logic          w_push;
    logic [31:0]   w_wdata;
    logic          w_err_next;
    logic [31:0]   w_enc;
    logic          w_legal;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    // Single-word encoding of the request; LI yields its first (or only) word.
    always_comb begin
        w_enc   = '0;
        w_legal = 1'b1;
        case (bus.in_op)
            OP_ADDU:  w_enc = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'h00, 6'h21};
            OP_SUBU:  w_enc = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'h00, 6'h23};
            OP_SLT:   w_enc = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'h00, 6'h2A};
            OP_JR:    w_enc = {6'h00, bus.in_rs, 5'h00, 5'h00, 5'h00, 6'h08};
            OP_ORI:   w_enc = {6'h0D, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            OP_LW:    w_enc = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            OP_SW:    w_enc = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            OP_BEQ:   w_enc = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            OP_LUI:   w_enc = {6'h0F, 5'h00, bus.in_rt, bus.in_imm[15:0]};
            OP_J:     w_enc = {6'h02, bus.in_imm[25:0]};
            OP_ADDI:  w_enc = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            OP_ADDIU: w_enc = {6'h09, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            OP_JAL:   w_enc = {6'h03, bus.in_imm[25:0]};
`ifdef INSTR_ENCODER_LI_EN
            OP_LI: begin
                if (bus.in_imm[31:16] == 16'h0000)
                    w_enc = {6'h0D, 5'h00, bus.in_rt, bus.in_imm[15:0]};
                else
                    w_enc = {6'h0F, 5'h00, bus.in_rt, bus.in_imm[31:16]};
            end
`endif
            default:  w_legal = 1'b0;
        endcase
    end

`ifdef INSTR_ENCODER_LI_EN
    typedef enum logic [0:0] {S_IDLE, S_LI_LO} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_li_rt;
    logic [15:0] r_li_lo;

    assign w_in_ready = (r_state == S_IDLE) && !w_full;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_li_rt <= bus.in_rt;
            r_li_lo <= bus.in_imm[15:0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_wdata      = '0;
        w_err_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_legal) begin
                        w_push  = 1'b1;
                        w_wdata = w_enc;
                        if (bus.in_op == OP_LI && bus.in_imm[31:16] != 16'h0000)
                            w_state_next = S_LI_LO;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            S_LI_LO: begin
                // A pop in this cycle does not help; room is judged on the current count.
                if (!w_full) begin
                    w_push       = 1'b1;
                    w_wdata      = {6'h0D, r_li_rt, r_li_rt, r_li_lo};
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end
`else
    logic w_unused_imm;

    assign w_unused_imm = ^bus.in_imm[31:26];
    assign w_in_ready   = !w_full;

    always_comb begin
        w_push     = w_accept && w_legal;
        w_wdata    = w_enc;
        w_err_next = w_accept && !w_legal;
    end
`endif

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err_next;
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_instr = r_mem[r_rptr];
    assign bus.err       = r_err;
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning output FIFO entries (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request carries an instruction to encode.
REQ-005 SHALL have port in_ready  output  1  encoder accepts the request this cycle.
REQ-006 SHALL have port in_op  input  4  op select: 0 ADDU, 1 SUBU, 2 SLT, 3 JR, 4 ORI, 5 LW, 6 SW, 7 BEQ, 8 LUI, 9 J, 10 ADDI, 11 ADDIU, 12 JAL, 13 LI, 14-15 illegal.
REQ-007 SHALL have ports in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-008 SHALL have port in_imm  input  32  immediate: [15:0] for I-type, [25:0] for J-type, [31:0] for LI.
REQ-009 SHALL have port out_valid  output  1  out_instr holds a valid word.
REQ-010 SHALL have port out_ready  input  1  consumer takes the word this cycle.
REQ-011 SHALL have port out_instr  output  32  encoded MIPS instruction word (FIFO head).
REQ-012 SHALL have port err  output  1  one-cycle pulse on an accepted illegal op.

Function
REQ-013 SHALL accept a request when in_valid && in_ready; SHALL pop the FIFO head when out_valid && out_ready.
REQ-014 SHALL encode R-type as {6'h00, rs, rt, rd, 5'h0, funct}, with funct ADDU 6'h21, SUBU 6'h23, SLT 6'h2A, JR 6'h08; for JR, rt and rd fields forced to 0.
REQ-015 SHALL encode I-type as {opcode, rs, rt, imm[15:0]}, with opcode ORI 6'h0D, LW 6'h23, SW 6'h2B, BEQ 6'h04, LUI 6'h0F (rs forced 0), ADDI 6'h08, ADDIU 6'h09.
REQ-016 SHALL encode J-type as {opcode, imm[25:0]}, with opcode J 6'h02, JAL 6'h03.
REQ-017 SHALL run FSM states IDLE and LI_LO; in_ready = (state==IDLE) && FIFO not full.
REQ-018 SHALL, in IDLE on an accepted non-LI legal op, write one word into the FIFO; the word is visible on out_instr no earlier than the next cycle.
REQ-019 SHALL NOT pass a word through combinationally; a pop in the same cycle does not raise in_ready when the FIFO is full.
REQ-020 SHALL support simultaneous push and pop in one cycle without changing count.
REQ-021 SHALL keep out_valid = (count != 0); pointers wrap modulo DEPTH; count width is log2(DEPTH)+1.
REQ-022 SHALL, on an accepted illegal op, write nothing and assert err for exactly the next cycle.
REQ-023 SHALL hold out_instr stable while out_valid && !out_ready.

Reset
REQ-024 SHALL, when rst is high at a clock edge, set state to IDLE, empty the FIFO (pointers and count 0), and clear err; out_valid=0 and in_ready=1 in the following cycle.
REQ-025 SHALL, on reset in LI_LO, discard the pending low half and all queued words.

Configuration
REQ-026 SHALL gate LI support with macro INSTR_ENCODER_LI_EN.
REQ-027 SHALL, with INSTR_ENCODER_LI_EN defined: if imm[31:16]==0, write one word ORI rt,$0,imm[15:0]; otherwise write LUI rt,imm[31:16], enter LI_LO, and with in_ready low write ORI rt,rt,imm[15:0] on the first cycle the FIFO is not full, then return to IDLE.
REQ-028 SHALL, without INSTR_ENCODER_LI_EN, treat op 13 as illegal per REQ-022; no LI_LO state logic is built.

Verification
REQ-029 SHALL cover: ADDU rs=1 rt=2 rd=3 -> out_instr 0x00221821 one cycle later.
REQ-030 SHALL cover: LI rt=8 imm=0x12345678 (macro on) -> 0x3C081234 then 0x35085678; LI rt=9 imm=0x000000FF -> single 0x340900FF.
REQ-031 SHALL cover: J imm=0x0100000 -> 0x08100000; JR rs=31 rt=5 rd=7 -> 0x03E00008.
REQ-032 SHALL cover: out_ready=0, push 4 ADDU (DEPTH=4) -> in_ready=0 after 4th; one pop -> in_ready=1 the next cycle, order preserved.
REQ-033 SHALL cover: op 14, or op 13 with macro off -> err high one cycle, out_valid stays 0.
REQ-034 SHALL cover: FIFO full, LI accepted, rst asserted in LI_LO -> next cycle out_valid=0, in_ready=1, no ORI emitted.
